// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared FSM states and sizing helpers for the multi-port register file
package regfile_pkg;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam int DEF_ADDR_W = 5;
  localparam int DEPTH      = 1 << DEF_ADDR_W;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port with write forwarding and zero-register mask
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              run,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic              zero_hit;
  logic              fwd_hit;
  logic [DATA_W-1:0] rd_next;

  // The zero mask wins over forwarding so r0 never leaks a forwarded write.
  always_comb begin
    zero_hit = (ZERO_REG != 0) && (rd_addr == '0);
    fwd_hit  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
    rd_next  = mem_data;
    if (zero_hit) begin
      rd_next = '0;
    end else if (fwd_hit) begin
      rd_next = wr_data;
    end
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= run && rd_en;
      if (run && rd_en) begin
        rd_data <= rd_next;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with post-reset clear sweep
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     cclk,
  input  logic                     rst,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy
);

  localparam int RF_DEPTH = depth_of(ADDR_W);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic              run;
  logic              wr_go;
  logic [DATA_W-1:0] mem [RF_DEPTH];

  always_ff @(posedge cclk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The edge that clears the last entry also moves to RUN, so busy drops there.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == ST_CLEAR) begin
      cnt_next = cnt + ADDR_W'(1);
      if (&cnt) begin
        state_next = ST_RUN;
      end
    end
  end

  assign run   = (state == ST_RUN);
  assign busy  = (state == ST_CLEAR);
  assign wr_go = run && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge cclk) begin
    if (!rst) begin
      if (!run) begin
        mem[cnt] <= '0;
      end else if (wr_go) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .cclk    (cclk),
      .rst     (rst),
      .run     (run),
      .rd_en   (rd_en[p]),
      .rd_addr (rd_addr[p*ADDR_W +: ADDR_W]),
      .mem_data(mem[rd_addr[p*ADDR_W +: ADDR_W]]),
      .wr_en   (wr_go),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid(rd_valid[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass/zero-reg build and read-first/no-zero build)
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic cclk = 1'b0;
  always #5 cclk = ~cclk;

  logic               rst;
  logic [NR-1:0]      rd_en;
  logic [NR*AW-1:0]   rd_addr;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [NR*DW-1:0]   rd_data_a, rd_data_b;
  logic [NR-1:0]      rd_valid_a, rd_valid_b;
  logic               busy_a, busy_b;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .cclk(cclk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy_a)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .cclk(cclk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy_b)
  );

  // Reference model: a = zero-reg + write-first, b = plain read-first.
  logic [DW-1:0] ma [DEPTH];
  logic [DW-1:0] mb [DEPTH];
  logic [DW-1:0] ea [NR];
  logic [DW-1:0] eb [NR];
  logic [NR-1:0] va, vb;
  int            sweep_left = DEPTH;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot(input logic [NR*DW-1:0] bus, input int p);
    return bus[p*DW +: DW];
  endfunction

  task automatic model_edge();
    logic [AW-1:0] a;
    if (rst) begin
      sweep_left = DEPTH;
      va = '0;
      vb = '0;
      for (int p = 0; p < NR; p++) begin
        ea[p] = '0;
        eb[p] = '0;
      end
    end else if (sweep_left > 0) begin
      va = '0;
      vb = '0;
      sweep_left--;
      if (sweep_left == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          ma[i] = '0;
          mb[i] = '0;
        end
      end
    end else begin
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        va[p] = rd_en[p];
        vb[p] = rd_en[p];
        if (rd_en[p]) begin
          if (a == 0) ea[p] = '0;
          else if (wr_en && wr_addr == a) ea[p] = wr_data;
          else ea[p] = ma[a];
          eb[p] = mb[a];
        end
      end
      if (wr_en) begin
        if (wr_addr != 0) ma[wr_addr] = wr_data;
        mb[wr_addr] = wr_data;
      end
    end
  endtask

  task automatic check_all();
    chk("busy_a", 64'(busy_a), 64'(sweep_left > 0));
    chk("busy_b", 64'(busy_b), 64'(sweep_left > 0));
    chk("valid_a", 64'(rd_valid_a), 64'(va));
    chk("valid_b", 64'(rd_valid_b), 64'(vb));
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("data_a[%0d]", p), 64'(slot(rd_data_a, p)), 64'(ea[p]));
      chk($sformatf("data_b[%0d]", p), 64'(slot(rd_data_b, p)), 64'(eb[p]));
    end
  endtask

  task automatic cycle();
    @(posedge cclk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rd_en = '0;
    wr_en = 1'b0;
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy_a && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, 64'(n), 64'(DEPTH));
  endtask

  initial begin
    rst = 1'b1;
    rd_en = '0;
    rd_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 3; i++) cycle();

    // Sweep with requests that must be ignored.
    rst = 1'b0;
    rd_en = 2'b11;
    rd_addr = {5'd5, 5'd5};
    wr_en = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hAAAA5555;
    count_busy("sweep_len");
    idle();

    for (int a = 0; a < DEPTH; a += 2) begin
      rd_en = 2'b11;
      rd_addr = {5'(a + 1), 5'(a)};
      cycle();
      chk("clear_valid", 64'(rd_valid_a), 64'h3);
      chk("clear_lo", 64'(slot(rd_data_a, 0)), 64'h0);
      chk("clear_hi", 64'(slot(rd_data_a, 1)), 64'h0);
    end
    idle();

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    cycle();
    idle();
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    cycle();
    chk("r7_p0", 64'(slot(rd_data_a, 0)), 64'hDEADBEEF);
    chk("r7_p1", 64'(slot(rd_data_a, 1)), 64'hDEADBEEF);
    chk("r7_valid", 64'(rd_valid_a), 64'h3);
    idle();

    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
    rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
    cycle();
    chk("byp_a", 64'(slot(rd_data_a, 1)), 64'h12345678);
    chk("byp_b_old", 64'(slot(rd_data_b, 1)), 64'h0);
    idle();
    rd_en = 2'b10;
    cycle();
    chk("byp_b_new", 64'(slot(rd_data_b, 1)), 64'h12345678);

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_en = 2'b11; rd_addr = '0;
    cycle();
    chk("r0_same_a", 64'(slot(rd_data_a, 0)), 64'h0);
    wr_en = 1'b0;
    cycle();
    chk("r0_next_a", 64'(slot(rd_data_a, 1)), 64'h0);
    chk("r0_next_b", 64'(slot(rd_data_b, 0)), 64'hFFFFFFFF);
    idle();

    // Reset mid-sweep.
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    count_busy("midsweep_len");

    // Reset mid-run wipes r9.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADF00D;
    cycle();
    wr_en = 1'b0;
    rst = 1'b1; rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
    cycle(); cycle();
    chk("rst_valid", 64'(rd_valid_a), 64'h0);
    rst = 1'b0;
    count_busy("rerun_len");
    cycle();
    chk("r9_wiped", 64'(slot(rd_data_a, 0)), 64'h0);
    chk("r9_valid", 64'(rd_valid_a), 64'h3);
    idle();

    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      rd_en = NR'($urandom_range(0, 3));
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; next generation of the MIPS-stub 32x32 register file.
- Generalised in data width, depth and read-port count. Adds a hardwired zero register, selectable write-to-read bypass, per-port read enables with valid flags, and a post-reset clear sweep with a busy flag.
- Sits between the decode stage (addresses) and the ALU operand latches (read data); the writeback stage drives the write port.

Parameters:
- DATA_W, 32, bits per register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write visible on read (write-first); 0 = read returns old value (read-first)

Ports:
- cclk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- rd_en  in  N_RD  per-port read request
- rd_addr  in  N_RD*ADDR_W  port p address at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_valid  out  N_RD  per-port: rd_data valid this cycle
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- busy  out  1  clear sweep in progress; all requests ignored

Behaviour:
- One clock, cclk. Synchronous active-high reset, rst.
- Reset, sampled at rst=1 edge:
  - rd_data=0, rd_valid=0, busy=1
  - FSM=CLEAR, sweep counter=0
  - array contents are not touched by reset itself
- FSM states:
  - CLEAR:
    - each cycle with rst=0: array[cnt]<=0, cnt<=cnt+1
    - at cnt=DEPTH-1: go to RUN and drop busy at that same edge
    - exactly DEPTH edges after rst deasserts, busy=0
  - RUN: normal operation; stays in RUN until rst.
- rst asserted mid-sweep or mid-RUN: counter restarts at 0 and the full sweep repeats.
- During CLEAR:
  - rd_en and wr_en are ignored
  - rd_valid=0
  - rd_data holds 0
- Read in RUN, latency 1:
  - rd_en[p]=1 at edge N gives rd_data[p]=array[rd_addr[p]] and rd_valid[p]=1 after edge N.
  - rd_en[p]=0 gives rd_valid[p]=0 next cycle; rd_data[p] holds its last value.
- Write in RUN: wr_en=1 gives array[wr_addr]<=wr_data at the edge. No write backpressure.
- Same-cycle write and read to the same address:
  - BYPASS=1: rd_data=wr_data
  - BYPASS=0: rd_data=old content
  - applies independently to every port
- ZERO_REG=1:
  - writes to address 0 are dropped
  - reads of address 0 return 0, including when bypass would otherwise forward a write to address 0
- Multiple ports may read the same address in the same cycle with no conflict.
- No X on outputs after reset; array contents before the first sweep completes are don't-care internally, never visible.

Decomposition:
- Shared package regfile_pkg holds:
  - FSM state enum (ST_CLEAR, ST_RUN)
  - helper constant DEPTH derived from ADDR_W
- One natural sub-module, regfile_rd_port: a single registered read port containing bypass compare, zero-register mask and valid flop. It is instantiated N_RD times via generate.
- The storage array, write logic and clear FSM stay in the top module.

Test Plan:
- Reset then sweep: rst=1 for 3 cycles, release → busy=1 for exactly 32 cycles, then 0. A read of all 32 addresses returns 0x00000000 with rd_valid=1.
- Write/read, latency 1: write 0xDEADBEEF to r7. The next cycle, read r7 on port 0 and r7 on port 1 → both 0xDEADBEEF one cycle later, rd_valid=2'b11.
- Bypass:
  - BYPASS=1: write 0x12345678 to r3 while port 1 reads r3 (old 0x0) → rd_data[1]=0x12345678.
  - BYPASS=0 build: same stimulus → 0x00000000, and 0x12345678 on the following read.
- Zero register: write 0xFFFFFFFF to r0, same cycle and next cycle read r0 → 0x00000000 both times. ZERO_REG=0 build → 0xFFFFFFFF on the following read.
- Ignored during sweep: wr_en=1 to r5=0xAAAA5555 and rd_en=2'b11 during busy → rd_valid stays 0. After busy falls, r5 reads 0x00000000.
- Reset mid-sweep and mid-operation:
  - rst pulsed at sweep cycle 10 → busy stays high 32 further cycles.
  - rst pulsed in RUN after r9=0x0BADF00D → r9 reads 0 after the new sweep; rd_valid=0 throughout reset.
